bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 98 +++++++++
 tb/tb_bin2bcd_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble),
// one input bit per clock, with leading-zero blanking flags for display drivers.
module bin2bcd_seq #(
  parameter int N = 16,
  parameter int D = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic [D-1:0]   blank
);

  localparam int CW = $clog2(N + 1);
  // Reset/zero display: every digit blanked except the ones digit.
  localparam logic [D-1:0] BLANK_RST = ~D'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_next;
  logic [4*D-1:0] scratch;
  logic [4*D-1:0] adj;
  logic [4*D-1:0] scratch_shifted;
  logic [N-1:0]   shadow;
  logic [CW-1:0]  cnt;
  logic [D-1:0]   blank_next;
  logic           zero_above;
  logic           last;

  always_comb begin
    adj = scratch;
    for (int i = 0; i < D; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    scratch_shifted = {adj[4*D-2:0], shadow[N-1]};
  end

  // Blank flags are computed from the final scratch so they land with bcd.
  always_comb begin
    blank_next = '0;
    zero_above = 1'b1;
    for (int i = D - 1; i >= 1; i--) begin
      zero_above    = zero_above & (scratch_shifted[4*i +: 4] == 4'd0);
      blank_next[i] = zero_above;
    end
  end

  assign last = (cnt == CW'(1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      scratch <= '0;
      shadow  <= '0;
      cnt     <= '0;
      bcd     <= '0;
      blank   <= BLANK_RST;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            shadow  <= bin;
            scratch <= '0;
            cnt     <= CW'(N);
          end
        end
        SHIFT: begin
          scratch <= scratch_shifted;
          shadow  <= shadow << 1;
          cnt     <= cnt - CW'(1);
          if (last) begin
            bcd   <= scratch_shifted;
            blank <= blank_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 16-bit/5-digit instance with directed vectors
// and a 6-bit/2-digit instance swept over every input value.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start16, start6;
  logic [15:0] bin16;
  logic [5:0]  bin6;
  logic        busy16, done16, busy6, done6;
  logic [19:0] bcd16;
  logic [4:0]  blank16;
  logic [7:0]  bcd6;
  logic [1:0]  blank6;

  bin2bcd_seq #(.N(16), .D(5)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .bin(bin16),
    .busy(busy16), .done(done16), .bcd(bcd16), .blank(blank16)
  );

  bin2bcd_seq #(.N(6), .D(2)) dut6 (
    .clk(clk), .reset(reset), .start(start6), .bin(bin6),
    .busy(busy6), .done(done6), .bcd(bcd6), .blank(blank6)
  );

  typedef struct {
    logic [19:0] bcd;
    logic [4:0]  blank;
    int          accept;
  } exp_t;

  exp_t q16[$];
  exp_t q6[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors pop one expectation per done pulse; a pulse with nothing pending is an error.
  always @(negedge clk) begin : mon16
    exp_t e;
    if (done16) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done16 actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = q16.pop_front();
        check_output("bcd16", 32'(bcd16), 32'(e.bcd));
        check_output("blank16", 32'(blank16), 32'(e.blank));
        check_output("latency16", 32'(cyc - e.accept), 32'd16);
      end
    end
  end

  always @(negedge clk) begin : mon6
    exp_t e;
    if (done6) begin
      if (q6.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done6 actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = q6.pop_front();
        check_output("bcd6", 32'(bcd6), 32'(e.bcd[7:0]));
        check_output("blank6", 32'(blank6), 32'(e.blank[1:0]));
        check_output("latency6", 32'(cyc - e.accept), 32'd6);
      end
    end
  end

  task automatic wait_idle16();
    int n = 0;
    while (busy16 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy16) check_output("timeout_idle16", 32'(busy16), 32'd0);
  endtask

  task automatic wait_idle6();
    int n = 0;
    while (busy6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy6) check_output("timeout_idle6", 32'(busy6), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((q16.size() != 0 || q6.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_q16", 32'(q16.size()), 32'd0);
    check_output("drain_q6", 32'(q6.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  // Issue one 16-bit conversion; bin is scrambled afterwards to prove it was latched.
  task automatic apply_stimulus(input logic [15:0] v, input logic [19:0] eb, input logic [4:0] ebl);
    wait_idle16();
    bin16   = v;
    start16 = 1'b1;
    q16.push_back('{eb, ebl, cyc + 1});
    @(negedge clk);
    start16 = 1'b0;
    bin16   = ~v;
  endtask

  task automatic apply_stimulus6(input int v);
    exp_t e;
    wait_idle6();
    bin6     = 6'(v);
    start6   = 1'b1;
    e.bcd    = {12'h000, 4'(v / 10), 4'(v % 10)};
    e.blank  = {3'b000, (v < 10), 1'b0};
    e.accept = cyc + 1;
    q6.push_back(e);
    @(negedge clk);
    start6 = 1'b0;
    bin6   = ~6'(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_busy"}, 32'(busy16), 32'd0);
    check_output({tag, "_done"}, 32'(done16), 32'd0);
    check_output({tag, "_bcd"}, 32'(bcd16), 32'h0);
    check_output({tag, "_blank"}, 32'(blank16), 32'b11110);
  endtask

  logic [15:0] vec_bin[9]   = '{16'd0, 16'd65535, 16'd42, 16'd9, 16'd10, 16'd100,
                                16'd10000, 16'd1234, 16'd40960};
  logic [19:0] vec_bcd[9]   = '{20'h00000, 20'h65535, 20'h00042, 20'h00009, 20'h00010,
                                20'h00100, 20'h10000, 20'h01234, 20'h40960};
  logic [4:0]  vec_blank[9] = '{5'b11110, 5'b00000, 5'b11100, 5'b11110, 5'b11100,
                                5'b11000, 5'b00000, 5'b10000, 5'b00000};

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : main
    int n;
    reset   = 1'b1;
    start16 = 1'b0;
    start6  = 1'b0;
    bin16   = '0;
    bin6    = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check_output("reset_blank6", 32'(blank6), 32'b10);
    check_output("reset_bcd6", 32'(bcd6), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) apply_stimulus(vec_bin[i], vec_bcd[i], vec_blank[i]);
    drain();

    // A request arriving mid-conversion must be dropped entirely.
    apply_stimulus(16'd7, 20'h00007, 5'b11110);
    repeat (3) @(negedge clk);
    check_output("busy_mid", 32'(busy16), 32'd1);
    bin16   = 16'd100;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    drain();
    repeat (20) @(negedge clk);

    // Abort a conversion with reset; no done may appear and outputs return to reset values.
    wait_idle16();
    bin16   = 16'd999;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (4) @(negedge clk);
    check_output("busy_before_abort", 32'(busy16), 32'd1);
    reset = 1'b1;
    start16 = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    start16 = 1'b0;
    reset   = 1'b0;
    repeat (20) @(negedge clk);
    check_output("abort_idle", 32'(busy16), 32'd0);
    apply_stimulus(16'd999, 20'h00999, 5'b11000);
    drain();

    // Held start: back-to-back conversions every N+2 = 18 cycles.
    wait_idle16();
    bin16 = 16'd1234;
    q16.push_back('{20'h01234, 5'b10000, cyc + 1});
    q16.push_back('{20'h01234, 5'b10000, cyc + 19});
    q16.push_back('{20'h01234, 5'b10000, cyc + 37});
    start16 = 1'b1;
    n = 0;
    while (q16.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    start16 = 1'b0;
    drain();

    for (int v = 0; v < 64; v++) apply_stimulus6(v);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
